// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter
//   Round-robin arbiter that shares one single-port, read-only sprite ROM
//   between NREQ overlay requesters. A winner may keep the port for up to
//   MAX_BURST consecutive issues, so that a scanline segment can stream
//   without interruption. Read data is returned tagged with the requester
//   ID. When the data is not valid it is forced to black.
//
// Ports
//   clk       clock
//   reset     synchronous, active-high reset
//   req       per-requester read request (level)
//   addr      packed request addresses; requester i uses [i*AW +: AW]
//   gnt       one-hot; bit i means requester i's address from the previous
//             cycle is being issued in this cycle
//   rom_en    ROM read enable
//   rom_addr  ROM address (the winner's addr, unmodified)
//   rom_data  ROM read data, valid ROM_LAT cycles after rom_en
//   rd_valid  rd_data / rd_id valid
//   rd_id     requester index that owns rd_data
//   rd_data   rom_data while rd_valid is high, otherwise 0
module sprite_rom_arbiter #(
  parameter int unsigned NREQ      = 3,
  parameter int unsigned AW        = 16,
  parameter int unsigned DW        = 12,
  parameter int unsigned ROM_LAT   = 1,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*AW-1:0]   addr,
  output logic [NREQ-1:0]      gnt,
  output logic                 rom_en,
  output logic [AW-1:0]        rom_addr,
  input  logic [DW-1:0]        rom_data,
  output logic                 rd_valid,
  output logic [1:0]           rd_id,
  output logic [DW-1:0]        rd_data
);

  localparam int unsigned   CW      = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CW-1:0] CntLast = CW'(MAX_BURST - 1);
  // Pointer starts at the last requester so that requester 0 wins first.
  localparam logic [1:0]    PtrInit = 2'(NREQ - 1);

  typedef enum logic [0:0] {StIdle, StOwn} state_e;

  state_e            state_q, state_d;
  logic [1:0]        ptr_q;      // last winner; also the current owner in StOwn
  logic [CW-1:0]     cnt_q, cnt_d;

  logic [NREQ-1:0]   gnt_q;
  logic              rom_en_q;
  logic [AW-1:0]     rom_addr_q;

  logic              found;
  logic [1:0]        next_idx;
  logic              issue;
  logic [1:0]        win;
  logic [AW-1:0]     win_addr;

  logic [ROM_LAT-1:0] vld_pipe_q;
  logic [1:0]         id_pipe_q [ROM_LAT];

  // Circular successor of base by off positions, off in 1..NREQ.
  function automatic logic [1:0] wrap_idx(input logic [1:0] base, input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return 2'(s);
  endfunction

  // First requester after the pointer. The search covers the pointer itself
  // last, so a lone owner whose burst is exhausted gets regranted directly.
  always_comb begin
    found    = 1'b0;
    next_idx = ptr_q;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      if (!found && req[wrap_idx(ptr_q, i)]) begin
        found    = 1'b1;
        next_idx = wrap_idx(ptr_q, i);
      end
    end
  end

  // Next-state and issue decision for this cycle.
  always_comb begin
    issue   = 1'b0;
    win     = ptr_q;
    cnt_d   = '0;
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          issue   = 1'b1;
          win     = next_idx;
          state_d = StOwn;
        end
      end
      StOwn: begin
        if (req[ptr_q] && (cnt_q != CntLast)) begin
          issue = 1'b1;
          win   = ptr_q;
          cnt_d = cnt_q + 1'b1;
        end else if (found) begin
          issue = 1'b1;
          win   = next_idx;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Winner's address, passed through bit-exact.
  always_comb begin
    win_addr = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (win == 2'(i)) win_addr = addr[i*AW +: AW];
    end
  end

  // Arbiter FSM and registered issue outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      ptr_q      <= PtrInit;
      cnt_q      <= '0;
      gnt_q      <= '0;
      rom_en_q   <= 1'b0;
      rom_addr_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      gnt_q    <= issue ? (NREQ'(1) << win) : '0;
      rom_en_q <= issue;
      if (issue) begin
        ptr_q      <= win;
        rom_addr_q <= win_addr;
      end
    end
  end

  // Return pipeline mirrors the ROM latency. While rom_en_q is high ptr_q
  // holds the ID of the read being issued.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe_q <= '0;
      for (int unsigned i = 0; i < ROM_LAT; i++) id_pipe_q[i] <= 2'd0;
    end else begin
      vld_pipe_q[0] <= rom_en_q;
      id_pipe_q[0]  <= rom_en_q ? ptr_q : 2'd0;
      for (int unsigned i = 1; i < ROM_LAT; i++) begin
        vld_pipe_q[i] <= vld_pipe_q[i-1];
        id_pipe_q[i]  <= id_pipe_q[i-1];
      end
    end
  end

  assign gnt      = gnt_q;
  assign rom_en   = rom_en_q;
  assign rom_addr = rom_addr_q;
  assign rd_valid = vld_pipe_q[ROM_LAT-1];
  assign rd_id    = id_pipe_q[ROM_LAT-1];
  assign rd_data  = {DW{rd_valid}} & rom_data;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Bench for sprite_rom_arbiter: a table of directed vectors, followed by
// hand-written sequences for three-way fairness, data gating, and reset in
// the middle of a burst.
module tb_sprite_rom_arbiter;

  localparam int unsigned NREQ = 3, AW = 16, DW = 12;

  localparam logic [AW-1:0] A0 = 16'h1000;
  localparam logic [AW-1:0] A1 = 16'h0123;
  localparam logic [AW-1:0] A2 = 16'hBEEF;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ-1:0]   gnt, gnt_b;
  logic              rom_en, rom_en_b;
  logic [AW-1:0]     rom_addr, rom_addr_b;
  logic [DW-1:0]     rom_data = '0;
  logic              rd_valid, rd_valid_b;
  logic [1:0]        rd_id, rd_id_b;
  logic [DW-1:0]     rd_data, rd_data_b;
  logic              rom_const = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sprite_rom_arbiter dut (
    .clk(clk), .reset(reset), .req(req), .addr(addr), .gnt(gnt), .rom_en(rom_en),
    .rom_addr(rom_addr), .rom_data(rom_data), .rd_valid(rd_valid), .rd_id(rd_id),
    .rd_data(rd_data)
  );

  sprite_rom_arbiter #(.MAX_BURST(1)) dut_b (
    .clk(clk), .reset(reset), .req(req), .addr(addr), .gnt(gnt_b), .rom_en(rom_en_b),
    .rom_addr(rom_addr_b), .rom_data(rom_data), .rd_valid(rd_valid_b), .rd_id(rd_id_b),
    .rd_data(rd_data_b)
  );

  function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
    return a[11:0] ^ 12'h5A5;
  endfunction

  // One-cycle-latency ROM model.
  always @(posedge clk) begin
    if (rom_en) rom_data <= rom_const ? 12'hABC : rom_fn(rom_addr);
  end

  function automatic logic [AW-1:0] id_addr(input logic [1:0] id);
    case (id)
      2'd0:    return A0;
      2'd1:    return A1;
      2'd2:    return A2;
      default: return '0;
    endcase
  endfunction

  function automatic logic [AW-1:0] gnt_addr(input logic [2:0] g);
    case (g)
      3'b001:  return A0;
      3'b010:  return A1;
      3'b100:  return A2;
      default: return '0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       rst;
    logic [2:0] req;
    logic [2:0] gnt;
    logic       vld;
    logic [1:0] id;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [2:0] q, input logic [2:0] g,
                     input logic v, input logic [1:0] id);
    vec_t e;
    e.rst = r; e.req = q; e.gnt = g; e.vld = v; e.id = id;
    vecs.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] exp3 [5];
    logic       prev;
    logic       cur;

    reset = 1'b1;
    req   = '0;
    addr  = {A2, A1, A0};

    // Reset state
    add(1, 3'b000, 3'b000, 0, 0);
    add(1, 3'b000, 3'b000, 0, 0);
    // Lone requester 1: continuous grants, rollover without a gap
    add(0, 3'b010, 3'b010, 0, 0);
    for (int i = 0; i < 5; i++) add(0, 3'b010, 3'b010, 1, 1);
    add(0, 3'b000, 3'b000, 1, 1);
    add(0, 3'b000, 3'b000, 0, 0);
    // Two-way burst rotation
    add(0, 3'b011, 3'b001, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 3'b011, 3'b001, 1, 0);
    add(0, 3'b011, 3'b010, 1, 0);
    for (int i = 0; i < 3; i++) add(0, 3'b011, 3'b010, 1, 1);
    add(0, 3'b011, 3'b001, 1, 1);
    for (int i = 0; i < 3; i++) add(0, 3'b011, 3'b001, 1, 0);
    add(0, 3'b000, 3'b000, 1, 0);
    add(0, 3'b000, 3'b000, 0, 0);
    // Owner drops early
    add(1, 3'b000, 3'b000, 0, 0);
    add(0, 3'b101, 3'b001, 0, 0);
    add(0, 3'b101, 3'b001, 1, 0);
    add(0, 3'b100, 3'b100, 1, 0);
    add(0, 3'b100, 3'b100, 1, 2);
    add(0, 3'b000, 3'b000, 1, 2);
    add(0, 3'b000, 3'b000, 0, 0);

    foreach (vecs[i]) begin
      reset = vecs[i].rst;
      req   = vecs[i].req;
      tick();
      chk($sformatf("v%0d gnt", i), 32'(gnt), 32'(vecs[i].gnt));
      chk($sformatf("v%0d rom_en", i), 32'(rom_en), 32'(|vecs[i].gnt));
      if (vecs[i].gnt != 3'b000 || vecs[i].rst)
        chk($sformatf("v%0d rom_addr", i), 32'(rom_addr), 32'(gnt_addr(vecs[i].gnt)));
      chk($sformatf("v%0d rd_valid", i), 32'(rd_valid), 32'(vecs[i].vld));
      if (vecs[i].vld)
        chk($sformatf("v%0d rd_id", i), 32'(rd_id), 32'(vecs[i].id));
      chk($sformatf("v%0d rd_data", i), 32'(rd_data),
          32'(vecs[i].vld ? rom_fn(id_addr(vecs[i].id)) : 12'h000));
    end

    // Three-way fairness with single-issue bursts
    exp3[0] = 3'b001; exp3[1] = 3'b010; exp3[2] = 3'b100;
    exp3[3] = 3'b001; exp3[4] = 3'b010;
    reset = 1'b1; req = '0;
    tick();
    reset = 1'b0; req = 3'b111;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("fair%0d gnt_b", k), 32'(gnt_b), 32'(exp3[k]));
    end

    // Data gating with a constant-output ROM and alternating requests
    req = '0; reset = 1'b1;
    tick();
    reset = 1'b0;
    rom_const = 1'b1;
    prev = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cur = (k % 2 == 0);
      req = cur ? 3'b001 : 3'b000;
      tick();
      chk($sformatf("gate%0d gnt", k), 32'(gnt), cur ? 32'h1 : 32'h0);
      chk($sformatf("gate%0d rd_valid", k), 32'(rd_valid), 32'(prev));
      chk($sformatf("gate%0d rd_data", k), 32'(rd_data), prev ? 32'hABC : 32'h0);
      prev = cur;
    end
    rom_const = 1'b0;

    // Reset in the middle of a burst
    req = '0; reset = 1'b1;
    tick();
    reset = 1'b0; req = 3'b001;
    tick();                                    // t1
    chk("rst gnt t1", 32'(gnt), 32'h1);
    chk("rst rom_addr t1", 32'(rom_addr), 32'(A0));
    tick();                                    // t2
    chk("rst rd_valid t2", 32'(rd_valid), 32'h1);
    tick();                                    // t3
    chk("rst gnt t3", 32'(gnt), 32'h1);
    reset = 1'b1;
    tick();                                    // t4
    chk("rst gnt t4", 32'(gnt), 32'h0);
    chk("rst rom_en t4", 32'(rom_en), 32'h0);
    chk("rst rom_addr t4", 32'(rom_addr), 32'h0);
    chk("rst rd_valid t4", 32'(rd_valid), 32'h0);
    chk("rst rd_id t4", 32'(rd_id), 32'h0);
    chk("rst rd_data t4", 32'(rd_data), 32'h0);
    reset = 1'b0;
    tick();                                    // t5
    chk("rst gnt t5", 32'(gnt), 32'h1);
    chk("rst rd_valid t5", 32'(rd_valid), 32'h0);
    tick();                                    // t6
    chk("rst rd_valid t6", 32'(rd_valid), 32'h1);
    chk("rst rd_id t6", 32'(rd_id), 32'h0);
    chk("rst rd_data t6", 32'(rd_data), 32'(rom_fn(A0)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
